wb_cmd_master: RTL and testbench

Wishbone classic single-cycle master that sits directly upstream of the MAC's Wishbone register slave port. It accepts register read/write commands on a valid/ready command channel and issues one Wishbone cycle per command. It returns read data or an error on a valid/ready response channel. It also turns the slave's interrupt line into a sticky pending flag for the control logic.

---
 rtl/wb_cmd_master.sv | 89 ++++++++
 tb/tb_wb_cmd_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command to Wishbone classic single-transfer master with sticky interrupt flag
module wb_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_we,
  output logic              wb_stb,
  output logic              wb_cyc,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack,
  input  logic              wb_intr,
  output logic              intr_pending,
  input  logic              intr_clr
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        intr_q;
  assign cmd_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      intr_q       <= 1'b0;
      intr_pending <= 1'b0;
      wb_cyc       <= 1'b0;
      wb_stb       <= 1'b0;
      wb_we        <= 1'b0;
      wb_adr       <= '0;
      wb_dat_o     <= '0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      intr_q       <= wb_intr;
      intr_pending <= (wb_intr && !intr_q) ? 1'b1 : intr_clr ? 1'b0 : intr_pending;
      case (state)
        IDLE: if (cmd_valid) begin
          wb_we    <= cmd_we;
          wb_adr   <= cmd_adr;
          wb_dat_o <= cmd_wdata;
          wb_cyc   <= 1'b1;
          wb_stb   <= 1'b1;
          cnt      <= '0;
          state    <= BUS;
        end
        // ack is checked first so it wins over a coincident timeout
        BUS: if (wb_ack) begin
          wb_cyc    <= 1'b0;
          wb_stb    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= wb_we ? '0 : wb_dat_i;
          state     <= RESP;
        end else begin
          cnt <= cnt + 16'd1;
          if (cnt == 16'(TIMEOUT - 1)) begin
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: scoreboard bench for wb_cmd_master with TIMEOUT=8
module tb_wb_cmd_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [7:0]  cmd_adr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i = '0;
  logic        wb_we, wb_stb, wb_cyc, wb_ack = 1'b0, wb_intr = 1'b0;
  logic        intr_pending, intr_clr = 1'b0;

  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  rsp_t exp_q[$];
  int vectors = 0, miscompares = 0;

  wb_cmd_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc),
    .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_intr(wb_intr),
    .intr_pending(intr_pending), .intr_clr(intr_clr)
  );

  always #5 clk = ~clk;

  // Response monitor: pops the scoreboard on every response handshake
  always @(posedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          miscompares++;
          $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  // Called right after a negedge; returns at the negedge of the first BUS cycle
  task automatic issue(input logic we, input logic [7:0] adr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_wdata = wd;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: got cmd_ready=%b, required 1", cmd_ready);
    end
    exp_q.push_back('{er, ee});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, rsp_valid, rsp_err, rsp_rdata, intr_pending} !== '0
        || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got cyc=%b stb=%b we=%b adr=%h dat=%h rv=%b err=%b rd=%h ip=%b rdy=%b, required all 0 and rdy=1",
               wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, rsp_valid, rsp_err, rsp_rdata, intr_pending, cmd_ready);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    issue(1'b1, 8'h04, 32'hDEADBEEF, 32'h0, 1'b0);
    vectors++;
    if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o} !== {3'b111, 8'h04, 32'hDEADBEEF} || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL write_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h rv=%b, required 1 1 1 04 deadbeef rv=0",
               wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, rsp_valid);
    end
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b1 || wb_stb !== 1'b0 || wb_cyc !== 1'b0 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL write_rsp: got rv=%b stb=%b cyc=%b rdy=%b, required 1 0 0 0", rsp_valid, wb_stb, wb_cyc, cmd_ready);
    end
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL write_ready_back: got rdy=%b rv=%b, required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    issue(1'b0, 8'h10, 32'hA5A5A5A5, 32'h12345678, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o} !== {3'b110, 8'h10, 32'hA5A5A5A5} || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL read_hold[%0d]: got cyc=%b stb=%b we=%b adr=%h dat=%h rv=%b, required 1 1 0 10 a5a5a5a5 rv=0",
                 i, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, rsp_valid);
      end
      if (i == 3) begin wb_ack = 1'b1; wb_dat_i = 32'h12345678; end
      @(negedge clk);
    end
    wb_ack = 1'b0; wb_dat_i = 32'hFFFF0000;
    vectors++;
    if (rsp_valid !== 1'b1 || wb_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL read_done: got rv=%b stb=%b, required 1 0", rsp_valid, wb_stb);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    issue(1'b0, 8'h20, 32'h0, 32'h0, 1'b1);
    wb_dat_i = 32'hCAFEF00D;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (wb_stb !== 1'b1 || wb_cyc !== 1'b1 || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_stb[%0d]: got stb=%b cyc=%b rv=%b, required 1 1 0", i, wb_stb, wb_cyc, rsp_valid);
      end
      @(negedge clk);
    end
    vectors++;
    if (wb_stb !== 1'b0 || wb_cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL timeout_abort: got stb=%b cyc=%b rv=%b err=%b rd=%h, required 0 0 1 1 0",
               wb_stb, wb_cyc, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    issue(1'b1, 8'h30, 32'h01020304, 32'h0, 1'b0);
    @(negedge clk);
    vectors++;
    if (wb_stb !== 1'b1 || wb_adr !== 8'h30) begin
      miscompares++;
      $display("FAIL after_timeout_bus: got stb=%b adr=%h, required 1 30", wb_stb, wb_adr);
    end
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL after_timeout_rsp: got rv=%b err=%b, required 1 0", rsp_valid, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(1'b1, 8'h40, 32'h00000001, 32'h0, 1'b0);
    wb_ack = 1'b1; wb_dat_i = 32'h0000FFFF;
    @(negedge clk);
    wb_ack = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h44; cmd_wdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || cmd_ready !== 1'b0
          || wb_stb !== 1'b0 || wb_cyc !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: got rv=%b rd=%h err=%b rdy=%b stb=%b cyc=%b, required 1 0 0 0 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, cmd_ready, wb_stb, wb_cyc);
      end
      wb_ack = (i == 2); wb_dat_i = 32'h00000BAD;
      @(negedge clk);
    end
    wb_ack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    issue(1'b0, 8'h44, 32'h55, 32'h87654321, 1'b0);
    vectors++;
    if (wb_stb !== 1'b1 || wb_adr !== 8'h44 || wb_we !== 1'b0) begin
      miscompares++;
      $display("FAIL post_bp_bus: got stb=%b adr=%h we=%b, required 1 44 0", wb_stb, wb_adr, wb_we);
    end
    wb_ack = 1'b1; wb_dat_i = 32'h87654321;
    @(negedge clk);
    wb_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_interrupt();
    wb_intr = 1'b1;
    #1;
    vectors++;
    if (intr_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL intr_early: got pending=%b, required 0", intr_pending);
    end
    @(negedge clk); @(negedge clk);
    vectors++;
    if (intr_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL intr_set: got pending=%b, required 1", intr_pending);
    end
    intr_clr = 1'b1;
    @(negedge clk);
    intr_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (intr_pending !== 1'b0) begin
        miscompares++;
        $display("FAIL intr_cleared[%0d]: got pending=%b, required 0", i, intr_pending);
      end
      @(negedge clk);
    end
    wb_intr = 1'b0;
    @(negedge clk);
    wb_intr = 1'b1; intr_clr = 1'b1;
    @(negedge clk);
    intr_clr = 1'b0;
    vectors++;
    if (intr_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL intr_set_wins: got pending=%b, required 1", intr_pending);
    end
    wb_intr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 8'h50; cmd_wdata = 32'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (wb_stb !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_stb: got stb=%b, required 1", wb_stb);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (wb_stb !== 1'b0 || wb_cyc !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async_drop: got stb=%b cyc=%b rv=%b, required 0 0 0", wb_stb, wb_cyc, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_ready: got cmd_ready=%b, required 1", cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || wb_stb !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_no_rsp[%0d]: got rv=%b stb=%b, required 0 0", i, rsp_valid, wb_stb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_backpressure();
    test_interrupt();
    test_reset_mid_bus();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
